// File: rtl/mod_pll_reset_sequencer.sv
// PLL supervisor: pulses PLL reset, qualifies lock, then releases the
// core and audio domain resets in order; retries on timeout, re-sequences on loss.
module mod_pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 64,
    parameter int unsigned MAX_RETRIES    = 4,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       retry,
    output logic       pll_rst,
    output logic       rst_core,
    output logic       rst_audio,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_REL_CORE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST   = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_cnt_q, retry_cnt_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic             lock_meta_q, locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             rst_core_q, rst_core_d;
    logic             rst_audio_q, rst_audio_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    // locked is asynchronous to refclk; only locked_s_q is used below
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            locked_s_q  <= lock_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_cnt_d = retry_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        if (retry) begin
            state_d     = S_PLL_RST;
            cnt_d       = '0;
            retry_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d = '0;
                        if (retry_cnt_q < RETRY_MAX) begin
                            state_d     = S_PLL_RST;
                            retry_cnt_d = retry_cnt_q + 8'd1;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_REL_CORE;
                        cnt_d   = '0;
                    end
                end
                S_REL_CORE: begin
                    if (!locked_s_q) begin
                        state_d = S_PLL_RST;
                        cnt_d   = '0;
                    end else if (cnt_q == STAG_LAST) begin
                        state_d     = S_RUN;
                        cnt_d       = '0;
                        retry_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!locked_s_q) begin
                        state_d = S_PLL_RST;
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_d = loss_cnt_q + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    always_comb begin
        pll_rst_d   = 1'b0;
        rst_core_d  = 1'b1;
        rst_audio_d = 1'b1;
        ready_d     = 1'b0;
        fail_d      = 1'b0;
        unique case (state_d)
            S_PLL_RST:   pll_rst_d = 1'b1;
            S_WAIT_LOCK: pll_rst_d = 1'b0;
            S_STABLE:    pll_rst_d = 1'b0;
            S_REL_CORE:  rst_core_d = 1'b0;
            S_RUN: begin
                rst_core_d  = 1'b0;
                rst_audio_d = 1'b0;
                ready_d     = 1'b1;
            end
            S_FAIL:      fail_d = 1'b1;
            default:     pll_rst_d = 1'b1;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            rst_core_q  <= 1'b1;
            rst_audio_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_rst_q   <= pll_rst_d;
            rst_core_q  <= rst_core_d;
            rst_audio_q <= rst_audio_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign rst_core  = rst_core_q;
    assign rst_audio = rst_audio_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;
    assign loss_cnt  = loss_cnt_q;

endmodule
